// File: rtl/debounced_inputs_pkg.sv
// Shared types for the debounced input front end.
//   dbi_reg_e   : word offsets (adr[3:2]) of the four bus-visible registers
//   dbi_regs_t  : 32-bit view of the register file as presented on the bus
//   dbi_ch_mask : mask of the implemented channel bits for a given channel count
package debounced_inputs_pkg;

  typedef enum logic [1:0] {
    DBI_STATE  = 2'd0,
    DBI_RISE   = 2'd1,
    DBI_FALL   = 2'd2,
    DBI_IRQ_EN = 2'd3
  } dbi_reg_e;

  typedef struct packed {
    logic [31:0] state;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] irq_en;
  } dbi_regs_t;

  function automatic logic [31:0] dbi_ch_mask(input int unsigned n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Minimal wishbone bundle for single-cycle-ack register slaves.
//   cyc/stb/we/adr/dat_w : master -> slave request
//   dat_r/ack            : slave -> master response
// Only the word select adr[3:2] is carried; the slave decodes nothing else.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:2]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
endinterface

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, debounce counter, edge events.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   raw_i         : asynchronous pad level
//   state_o       : debounced level
//   rise_o/fall_o : single-cycle strobes, high in the cycle whose closing edge
//                   updates state_o (combinational, for the sticky flags)
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 5_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   event_d;

  assign s = sync_q[SYNC_STAGES-1];

  // A sample equal to the accepted level restarts the count, so a glitch
  // shorter than DEBOUNCE_CYCLES is rejected.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;
    if (s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = s;
      cnt_d   = '0;
      event_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = event_d &  s;
  assign fall_o  = event_d & ~s;

endmodule

// File: rtl/debounced_inputs.sv
// N-channel button/switch front end with sticky edge flags and a maskable
// level interrupt, exposed as a wishbone register slave.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inputs_i      : raw pad levels, one bit per channel
//   wb            : wishbone slave (STATE RO, RISE/FALL W1C, IRQ_EN RW)
//   irq_o         : registered |((RISE|FALL) & IRQ_EN)
module debounced_inputs
  import debounced_inputs_pkg::*;
#(
  parameter int unsigned N_CHANNELS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 5_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_CHANNELS-1:0] inputs_i,
  wb_if.slave                   wb,
  output logic                  irq_o
);

  localparam logic [31:0] CH_MASK = dbi_ch_mask(N_CHANNELS);

  logic [N_CHANNELS-1:0] state_w, rise_ev, fall_ev;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raw_i   (inputs_i[g]),
      .state_o (state_w[g]),
      .rise_o  (rise_ev[g]),
      .fall_o  (fall_ev[g])
    );
  end

  logic [31:0] rise_q, rise_d;
  logic [31:0] fall_q, fall_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic        ack_q;
  logic        irq_q, irq_d;
  logic        access, wr_en;
  logic [31:0] wmask;
  logic [31:0] rdata;
  dbi_regs_t   regs;

  assign access = wb.cyc & wb.stb & ~ack_q;
  assign wr_en  = access & wb.we;
  // Unimplemented channel bits are stripped here so they can never be set.
  assign wmask  = wb.dat_w & CH_MASK;

  // Clear first, then OR in new events: a same-cycle event beats W1C.
  always_comb begin
    rise_d   = rise_q;
    fall_d   = fall_q;
    irq_en_d = irq_en_q;
    if (wr_en) begin
      case (dbi_reg_e'(wb.adr))
        DBI_RISE:   rise_d   = rise_q & ~wmask;
        DBI_FALL:   fall_d   = fall_q & ~wmask;
        DBI_IRQ_EN: irq_en_d = wmask;
        default:    ;
      endcase
    end
    rise_d = rise_d | 32'(rise_ev);
    fall_d = fall_d | 32'(fall_ev);
  end

  assign irq_d = |((rise_q | fall_q) & irq_en_q);

  assign regs = '{state:  32'(state_w),
                  rise:   rise_q,
                  fall:   fall_q,
                  irq_en: irq_en_q};

  always_comb begin
    rdata = '0;
    if (ack_q) begin
      case (dbi_reg_e'(wb.adr))
        DBI_STATE:  rdata = regs.state;
        DBI_RISE:   rdata = regs.rise;
        DBI_FALL:   rdata = regs.fall;
        DBI_IRQ_EN: rdata = regs.irq_en;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      ack_q    <= access;
      irq_q    <= irq_d;
    end
  end

  assign wb.dat_r = rdata;
  assign wb.ack   = ack_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_debounced_inputs.sv
module tb_debounced_inputs;

  localparam int unsigned N  = 4;
  localparam int unsigned DC = 4;
  localparam int unsigned SS = 2;

  localparam logic [1:0] A_STATE  = 2'd0;
  localparam logic [1:0] A_RISE   = 2'd1;
  localparam logic [1:0] A_FALL   = 2'd2;
  localparam logic [1:0] A_IRQ_EN = 2'd3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] inputs;
  logic         irq;

  int n_tests;
  int n_fail;

  wb_if wb ();

  debounced_inputs #(
    .N_CHANNELS      (N),
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .inputs_i (inputs),
    .wb       (wb),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wb_access(input logic we, input logic [1:0] adr,
                           input logic [31:0] wdat, output logic [31:0] rdat);
    logic got_ack;
    got_ack   = 1'b0;
    wb.cyc    = 1'b1;
    wb.stb    = 1'b1;
    wb.we     = we;
    wb.adr    = adr;
    wb.dat_w  = wdat;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (wb.ack) begin
        got_ack = 1'b1;
        break;
      end
    end
    check("bus_ack", {31'd0, got_ack}, 32'd1);
    rdat     = wb.dat_r;
    wb.cyc   = 1'b0;
    wb.stb   = 1'b0;
    wb.we    = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_access(1'b1, adr, wdat, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(1'b0, adr, 32'd0, d);
    check(tag, d, exp);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    inputs   = '0;
    wb.cyc   = 1'b0;
    wb.stb   = 1'b0;
    wb.we    = 1'b0;
    wb.adr   = 2'd0;
    wb.dat_w = 32'd0;

    // Reset state
    ticks(3);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, wb.ack}, 32'd0);
    check("rst_dat_r", wb.dat_r, 32'd0);
    rst_n = 1'b1;
    ticks(2);
    wb_read_check("rst_state", A_STATE, 32'h0);
    tick();

    // 1: ch0 held high; first sampling edge E0, state updates at E5
    inputs = 4'b0001;
    ticks(4);                                // after E3
    wb_read_check("t1_state_e4", A_STATE, 32'h0);  // ack at E4
    tick();                                  // after E5
    check("t1_irq_masked_a", {31'd0, irq}, 32'd0);
    wb_read_check("t1_state_e6", A_STATE, 32'h1);
    tick();
    wb_read_check("t1_rise", A_RISE, 32'h1);
    tick();
    wb_read_check("t1_fall", A_FALL, 32'h0);
    tick();
    check("t1_irq_masked_b", {31'd0, irq}, 32'd0);
    wb_write(A_RISE, 32'h1);
    tick();
    wb_read_check("t1_rise_w1c", A_RISE, 32'h0);
    tick();

    // 2: two 3-sample pulses on ch1 separated by low samples -> rejected
    inputs = 4'b0011; ticks(3);
    inputs = 4'b0001; ticks(4);
    inputs = 4'b0011; ticks(3);
    inputs = 4'b0001; ticks(10);
    wb_read_check("t2_state", A_STATE, 32'h1);
    tick();
    wb_read_check("t2_rise", A_RISE, 32'h0);
    tick();
    wb_read_check("t2_fall", A_FALL, 32'h0);
    tick();

    // 3: interrupt path on ch0
    inputs = 4'b0000; ticks(10);
    wb_read_check("t3_prefall", A_FALL, 32'h1);
    tick();
    wb_write(A_FALL, 32'h1);
    tick();
    wb_write(A_IRQ_EN, 32'h1);
    tick();
    check("t3_irq_idle", {31'd0, irq}, 32'd0);
    inputs = 4'b0001;
    ticks(5);                                // after E4
    check("t3_irq_e4", {31'd0, irq}, 32'd0);
    tick();                                  // after E5: flag set, irq lags
    check("t3_irq_e5", {31'd0, irq}, 32'd0);
    tick();                                  // after E6
    check("t3_irq_e6", {31'd0, irq}, 32'd1);
    inputs = 4'b0000; ticks(10);
    wb_read_check("t3_rise", A_RISE, 32'h1);
    tick();
    wb_read_check("t3_fall", A_FALL, 32'h1);
    tick();
    wb_write(A_RISE, 32'h1);
    tick();
    check("t3_irq_fall_pending", {31'd0, irq}, 32'd1);
    wb_write(A_FALL, 32'h1);
    check("t3_irq_at_write", {31'd0, irq}, 32'd1);
    tick();
    check("t3_irq_cleared", {31'd0, irq}, 32'd0);
    tick();

    // 4: ch2 rise lands on the same edge as a W1C of RISE[2]
    inputs = 4'b0100;
    ticks(5);                                // after E4
    wb_write(A_RISE, 32'h4);                 // ack/write at E5
    tick();
    wb_read_check("t4_rise_set_wins", A_RISE, 32'h4);
    tick();
    wb_read_check("t4_state", A_STATE, 32'h4);
    tick();

    // 5: unimplemented bits, single-cycle ack, abandoned access, STATE write
    wb_write(A_IRQ_EN, 32'hFFFF_FFFF);
    tick();
    wb_read_check("t5_irq_en_mask", A_IRQ_EN, 32'h0000_000F);
    ticks(2);
    check("t5_irq_pending", {31'd0, irq}, 32'd1);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = A_STATE;
    tick();
    check("t5_ack_1cyc", {31'd0, wb.ack}, 32'd1);
    check("t5_ack_data", wb.dat_r, 32'h4);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    tick();
    check("t5_ack_low", {31'd0, wb.ack}, 32'd0);
    check("t5_dat_r_idle", wb.dat_r, 32'd0);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = A_IRQ_EN; wb.dat_w = 32'h0;
    #3;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    tick();
    check("t5_abandon_ack", {31'd0, wb.ack}, 32'd0);
    wb_read_check("t5_abandon_irq_en", A_IRQ_EN, 32'h0000_000F);
    tick();
    wb_write(A_STATE, 32'hFFFF_FFFF);
    tick();
    wb_read_check("t5_state_ro", A_STATE, 32'h4);
    tick();
    wb_write(A_IRQ_EN, 32'h0);
    tick();
    check("t5_irq_masked", {31'd0, irq}, 32'd0);
    wb_read_check("t5_rise_kept", A_RISE, 32'h4);
    tick();

    // 6: async reset mid-count, then exact latency after release
    wb_write(A_IRQ_EN, 32'h4);
    ticks(2);
    check("t6_irq_before_rst", {31'd0, irq}, 32'd1);
    inputs = 4'b0101;
    ticks(3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_irq_async", {31'd0, irq}, 32'd0);
    check("t6_rst_ack", {31'd0, wb.ack}, 32'd0);
    check("t6_rst_dat_r", wb.dat_r, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(5);                                // after E4
    wb_read_check("t6_state_e5", A_STATE, 32'h5);  // ack at E5
    tick();
    wb_read_check("t6_rise", A_RISE, 32'h5);
    tick();
    wb_read_check("t6_fall", A_FALL, 32'h0);
    tick();
    wb_read_check("t6_irq_en_rst", A_IRQ_EN, 32'h0);
    tick();
    check("t6_irq_off", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
